// File: rtl/enemy_pkg.sv
// Shared enemy definitions: direction codes, sprite/screen geometry, collision FSM encoding.
package enemy_pkg;

  typedef enum logic [2:0] {
    DIR_NO_ACTION = 3'd0,
    DIR_ATTACK    = 3'd1,
    DIR_UP        = 3'd2,
    DIR_DOWN      = 3'd3,
    DIR_LEFT      = 3'd4,
    DIR_RIGHT     = 3'd5
  } dir_e;

  localparam int SPRITE_SIZE = 16;
  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BOUNDS = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // Unsigned |a-b| computed as max-min so it never underflows.
  function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/enemy_collision_detector_box_overlap.sv
// Combinational 16x16 axis-aligned box overlap test between two top-left corners.
module box_overlap
  import enemy_pkg::*;
(
  input  logic [8:0] ax,
  input  logic [7:0] ay,
  input  logic [8:0] bx,
  input  logic [7:0] by,
  output logic       hit
);

  logic [9:0] w_dx;
  logic [9:0] w_dy;

  assign w_dx = abs_diff10({1'b0, ax}, {1'b0, bx});
  assign w_dy = abs_diff10({2'b00, ay}, {2'b00, by});
  assign hit  = (w_dx < 10'(SPRITE_SIZE)) && (w_dy < 10'(SPRITE_SIZE));

endmodule

// File: rtl/enemy_collision_detector.sv
// Per-move collision checker: screen bounds, 16 leading-edge obstacle pixels, and Link overlap.
module enemy_collision_detector
  import enemy_pkg::*;
#(
  parameter logic [8:0] X_MAX       = 9'd304,
  parameter logic [7:0] Y_MAX       = 8'd224,
  parameter logic       LINK_BLOCKS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  x_pos,
  input  logic [7:0]  y_pos,
  input  logic [2:0]  direction,
  input  logic [8:0]  link_x_pos,
  input  logic [7:0]  link_y_pos,
  output logic [16:0] map_address,
  input  logic        map_q,
  output logic        collision,
  output logic        hit_link,
  output logic        done
);

  logic [1:0] r_state;
  logic [8:0] r_x;
  logic [7:0] r_y;
  logic [2:0] r_dir;
  logic [8:0] r_link_x;
  logic [7:0] r_link_y;
  logic [3:0] r_idx;
  logic       r_acc;
  logic       r_q_valid;
  logic       r_overlap;
  logic       r_collision;
  logic       r_hit_link;
  logic       r_done;

  logic       w_dir_move;
  logic       w_bound_hit;
  logic [8:0] w_nx;
  logic [7:0] w_ny;
  logic       w_overlap;
  logic [8:0] w_ax;
  logic [7:0] w_ay;

  assign w_dir_move = (r_dir >= DIR_UP) && (r_dir <= DIR_RIGHT);

  always_comb begin
    w_bound_hit = 1'b0;
    w_nx        = r_x;
    w_ny        = r_y;
    case (r_dir)
      DIR_UP:    begin w_bound_hit = (r_y == 8'd0);  w_ny = r_y - 8'd1; end
      DIR_DOWN:  begin w_bound_hit = (r_y >= Y_MAX); w_ny = r_y + 8'd1; end
      DIR_LEFT:  begin w_bound_hit = (r_x == 9'd0);  w_nx = r_x - 9'd1; end
      DIR_RIGHT: begin w_bound_hit = (r_x >= X_MAX); w_nx = r_x + 9'd1; end
      default:   begin w_bound_hit = 1'b0; end
    endcase
  end

  box_overlap u_link_overlap (
    .ax  (w_nx),
    .ay  (w_ny),
    .bx  (r_link_x),
    .by  (r_link_y),
    .hit (w_overlap)
  );

  // Leading-edge pixel for the current scan index; zero outside SCAN.
  always_comb begin
    w_ax = 9'd0;
    w_ay = 8'd0;
    if (r_state == ST_SCAN) begin
      case (r_dir)
        DIR_UP:    begin w_ax = r_x + {5'd0, r_idx}; w_ay = r_y - 8'd1; end
        DIR_DOWN:  begin w_ax = r_x + {5'd0, r_idx}; w_ay = r_y + 8'd16; end
        DIR_LEFT:  begin w_ax = r_x - 9'd1;  w_ay = r_y + {4'd0, r_idx}; end
        DIR_RIGHT: begin w_ax = r_x + 9'd16; w_ay = r_y + {4'd0, r_idx}; end
        default:   begin w_ax = 9'd0; w_ay = 8'd0; end
      endcase
    end else begin
      w_ax = 9'd0;
      w_ay = 8'd0;
    end
  end

  assign map_address = {w_ay, w_ax};
  assign collision   = r_collision;
  assign hit_link    = r_hit_link;
  assign done        = r_done;

  // ROM data lags the address by one cycle, so r_q_valid marks cycles whose map_q belongs to a scan pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_x         <= 9'd0;
      r_y         <= 8'd0;
      r_dir       <= 3'd0;
      r_link_x    <= 9'd0;
      r_link_y    <= 8'd0;
      r_idx       <= 4'd0;
      r_acc       <= 1'b0;
      r_q_valid   <= 1'b0;
      r_overlap   <= 1'b0;
      r_collision <= 1'b0;
      r_hit_link  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_q_valid <= (r_state == ST_SCAN);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x      <= x_pos;
            r_y      <= y_pos;
            r_dir    <= direction;
            r_link_x <= link_x_pos;
            r_link_y <= link_y_pos;
            r_acc    <= 1'b0;
            r_state  <= ST_BOUNDS;
          end
        end
        ST_BOUNDS: begin
          if (!w_dir_move) begin
            r_collision <= 1'b0;
            r_hit_link  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_bound_hit) begin
            r_collision <= 1'b1;
            r_hit_link  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_overlap <= w_overlap;
            r_idx     <= 4'd0;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (r_q_valid) begin
            r_acc <= r_acc | map_q;
          end
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_hit_link  <= r_overlap;
          r_collision <= r_acc | map_q | (r_overlap & LINK_BLOCKS);
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/enemy_collision_detector.md
Name: enemy_collision_detector

Overview:
Per-move collision checker for one enemy. single_enemy samples `collision` in `apply_move`; this block produces that signal. Control pulses `start` after `gen_move` has latched `direction`, then waits for `done` before entering `apply_move`. The block checks three things for a one-pixel step: screen bounds, 16 leading-edge pixels of the 16x16 sprite against a 1-bit obstacle bitmap ROM, and overlap with Link.

Parameters:
X_MAX, 9'd304, largest legal sprite x (320-16)
Y_MAX, 8'd224, largest legal sprite y (240-16)
LINK_BLOCKS, 1'b1, 1 = Link overlap also asserts collision

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; ignored unless IDLE
x_pos  in  9  enemy x (top-left)
y_pos  in  8  enemy y (top-left)
direction  in  3  NO_ACTION/ATTACK/UP/DOWN/LEFT/RIGHT = 0/1/2/3/4/5
link_x_pos  in  9  Link x
link_y_pos  in  8  Link y
map_address  out  17  {y[7:0], x[8:0]} obstacle ROM address
map_q  in  1  obstacle bit; valid the cycle after the address is presented at a clock edge
collision  out  1  registered result; holds until next completion or reset
hit_link  out  1  registered; post-move box overlaps Link
done  out  1  registered one-cycle completion pulse

Behaviour:
- Clock/reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values: state=IDLE, collision=0, hit_link=0, done=0, map_address=0, idx=0, accumulator=0.
- IDLE: when `start`=1, latch x, y, direction, link_x and link_y. Clear the accumulator. Go to BOUNDS.
- BOUNDS (1 cycle):
  - direction not in 2..5: at the next edge collision<=0, hit_link<=0, done<=1, go to IDLE.
  - Bound hit (UP with y==0, DOWN with y>=Y_MAX, LEFT with x==0, RIGHT with x>=X_MAX): collision<=1, hit_link<=0, done<=1, go to IDLE.
  - Otherwise: compute the next position (nx, ny), one pixel in direction. Register the overlap flag: |nx-link_x|<16 and |ny-link_y|<16, using 10-bit unsigned subtract of max-min. Set idx=0 and go to SCAN.
- SCAN (16 cycles, idx 0..15): map_address is driven combinationally from the state:
  - UP: (x+idx, y-1)
  - DOWN: (x+idx, y+16)
  - LEFT: (x-1, y+idx)
  - RIGHT: (x+16, y+idx)
  - Arithmetic is at port width; the BOUNDS check guarantees no wrap.
  - idx increments each cycle. After idx==15, go to DRAIN.
  - A registered `q_valid` (in SCAN last cycle) gates accumulate |= map_q.
- DRAIN (1 cycle): fold in the final map_q. At the edge leaving DRAIN:
  - hit_link<=overlap
  - collision<=accumulate | (overlap & LINK_BLOCKS)
  - done<=1
  - go to IDLE
- No early exit; latency is fixed.
  - Start sampled at edge T0: done is high in cycle 2 for the bounds/no-action path and in cycle 19 for the scan path.
- done is deasserted in every cycle it is not being pulsed.
- start while not IDLE: ignored, with no effect on latched inputs.
- Input changes after the start edge have no effect.
- Reset at any point: immediate return to reset values; no done pulse follows.
- Back-to-back: start may be asserted in the same cycle that done is high, because the block is already IDLE in that cycle.

Decomposition:
- Shared package `enemy_pkg`:
  - direction codes NO_ACTION..RIGHT (also used by single_enemy)
  - SPRITE_SIZE=16
  - SCREEN_W=320, SCREEN_H=240
  - FSM state encoding
- One sub-module `box_overlap`: combinational 16x16 AABB test with inputs (ax, ay, bx, by) and output `hit`. Reusable by the Link-attack logic.

Test Plan:
1. UP, x=207, y=0 -> collision=1, hit_link=0, done in cycle 2, map_address never leaves 0.
2. RIGHT, (207,95), empty map, Link at (0,0):
   - map_address sweeps x=223, y=95..110 over cycles 2-17
   - collision=0, done in cycle 19 only
3. DOWN, (207,95), single obstacle bit at (210,111) -> collision=1, hit_link=0, done in cycle 19.
4. LEFT, (207,95), empty map:
   - Link (190,95) -> collision=0 (|206-190|=16)
   - Link (191,95) -> hit_link=1, collision=1
   - Repeat with LINK_BLOCKS=0 -> hit_link=1, collision=0
5. direction=NO_ACTION and direction=ATTACK -> collision=0, done in cycle 2. Second start during a scan (cycle 8) is ignored, with a single done pulse at cycle 19.
6. Reset asserted in cycle 10 of a RIGHT scan whose obstacle would hit -> collision=0 and no done. A fresh start after reset completes normally in 19 cycles.
